// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration and
// packet locking, feeding a single registered output stage.
module stream_mux_rr #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic          locked;
    logic [SW-1:0] lock_ch;

    logic          space;
    logic          grant_valid;
    logic [SW-1:0] grant;
    logic [SW-1:0] grant_nxt;
    logic          accept;
    int            idx;

    logic [W-1:0]  ch_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    assign space = !out_valid || out_ready;

    // Scan from the highest offset down so the lowest offset from ptr wins;
    // the modulo keeps candidates inside 0..N-1 for non-power-of-two N.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (locked) begin
            grant       = lock_ch;
            grant_valid = in_valid[lock_ch];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (in_valid[idx[SW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant       = idx[SW-1:0];
                end
            end
        end
    end

    // Gated by rst_n so nothing is acknowledged while reset is held.
    always_comb begin
        in_ready = '0;
        if (grant_valid && space && rst_n)
            in_ready[grant] = 1'b1;
    end

    assign accept    = |(in_valid & in_ready);
    assign grant_nxt = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant];
            out_last  <= in_last[grant];
            out_sel   <= grant;
            if (in_last[grant]) begin
                locked <= 1'b0;
                ptr    <= grant_nxt;
            end else begin
                locked  <= 1'b1;
                lock_ch <= grant;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer, the sequential successor to the team's fixed 4-bit 2:1 and 4:1 select muxes. The block takes `N` valid/ready input streams of `W`-bit beats and merges them onto one registered output stream. Selection is by round-robin arbitration with packet locking, so multi-beat packets are never interleaved. It sits between parallel producers (e.g. per-channel sample generators) and a single shared consumer.

## Interface
- `W`, default 4: data width per beat, 1 or more.
- `N`, default 4: number of input channels, 2 or more.
- `SW`, default `$clog2(N)`: derived select width, not overridden.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input N: bit i means channel i presents a beat.
- `in_data` input N*W: channel i occupies bits [i*W +: W].
- `in_last` input N: bit i marks the final beat of channel i's packet.
- `in_ready` output N: bit i means channel i's beat is accepted this cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output W: registered beat data.
- `out_last` output 1: registered last flag.
- `out_sel` output SW: index of the channel that sourced the current output beat.
- `out_ready` input 1: consumer accepts the output beat.

## Operation
- **State**
  - `ptr` (SW bits): round-robin start index.
  - `locked` (1 bit) and `lock_ch` (SW bits): packet lock.
  - One output register: valid, data, last, sel.
- **Space:** `space = !out_valid || out_ready`. This is the only combinational path from `out_ready` to `in_ready`.
- **Grant, unlocked:** the candidate is the first i with `in_valid[i]`=1, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`. There is no grant if all `in_valid` are 0.
- **Grant, locked:** the candidate is `lock_ch`, granted only if `in_valid[lock_ch]`=1. Other channels are stalled even if the locked channel idles.
- **Ready:** `in_ready[i] = grant_valid && grant == i && space`. At most one bit is set. `in_ready` may depend on `in_valid`, so producers must not wait for ready before asserting valid.
- **Accept:** an accept occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_valid`=1, `out_data`=`in_data[g]`, `out_last`=`in_last[g]`, `out_sel`=g.
- **Lock on accept:**
  - If `in_last[g]`=0: set `locked`=1 and `lock_ch`=g.
  - If `in_last[g]`=1: set `locked`=0 and `ptr`=(g+1) mod N, wrapping N-1 to 0.
  - A single-beat packet (last on its first beat) never locks and advances `ptr`.
- **Drain:** if `out_valid && out_ready` with no accept in the same cycle, clear `out_valid` next edge. `out_data`, `out_last` and `out_sel` hold their values.
- **Hold:** if `out_valid && !out_ready`, all output register fields hold and every `in_ready` is 0.
- **Non-power-of-two N:** `ptr` and `lock_ch` never take values of N or above. Scan arithmetic is mod N, not mod 2^SW.

## Timing
- **Reset (async assert, sync release):** `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0, `ptr`=0, `locked`=0. `in_ready`=0 while `rst_n`=0.
- **Latency:** one cycle from accept edge to `out_valid`.
- **Throughput:** one beat per cycle when `out_ready` is held high.
- **Simultaneous drain and accept:** the register is overwritten with the new beat and `out_valid` stays 1. There is no bubble.
- **Reset mid-packet:** the lock and any buffered beat are discarded. Arbitration restarts from channel 0.
- **Starvation bound:** once unlocked, a continuously valid channel is granted within N-1 packets of other channels.

## Test plan
- **Reset, then single-channel traffic.** Hold `rst_n`=0 with all inputs valid: outputs are 0 and `in_ready`=0. Release, then drive ch2 only with data 0xA, last=1, `out_ready`=1. Expect `in_ready`=4'b0100. One cycle later expect `out_valid`=1, `out_data`=0xA, `out_sel`=2. After the packet, `ptr`=3.
- **Round-robin fairness.** N=4, all channels continuously valid with single-beat packets, `out_ready`=1. Expect `out_sel` sequence 0,1,2,3,0,1 at one beat per cycle.
- **Packet lock.** Ch1 sends 3 beats with last on beat 3, ch0 and ch3 are valid throughout, and ch1's valid drops for 2 cycles mid-packet. Expect no ch0 or ch3 beats between ch1's beats. After ch1's last beat, the next grant goes to ch3, then ch0.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with a beat buffered. Expect `out_data` stable and `in_ready`=0. On the first `out_ready`=1 cycle, the buffered beat drains and a new beat is accepted in the same cycle, with `out_valid` staying 1.
- **Wrap and odd N.** With N=3 and W=8, ch2 sends last=1. Expect `ptr` to wrap to 0. With only ch1 valid afterwards, expect `out_sel`=1 and no out-of-range grant.
- **Async reset mid-packet.** Assert `rst_n` low asynchronously while ch0 is locked on beat 2 of 4. Expect `out_valid` to drop immediately. After release with ch1 and ch0 both valid, expect ch0 granted first (`ptr`=0, unlocked).
